// File: rtl/vxe_reg_rdport.sv
// Register read port: accepts indexed read requests and returns snapshots
// through a 2-entry in-order response buffer. Define VXE_REG_RDPORT_RANGE_CHECK_EN
// to flag out-of-range reads on rs_err.
module vxe_reg_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREGS*DATA_WIDTH-1:0] reg_data,
  input  logic                        rq_valid,
  input  logic [ADDR_WIDTH-1:0]       rq_addr,
  output logic                        rq_ready,
  output logic                        rs_valid,
  output logic [DATA_WIDTH-1:0]       rs_data,
  output logic                        rs_err,
  input  logic                        rs_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tail_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  push;
  logic                  pop;
  logic                  head_load;
  logic                  head_from_tail;
  logic                  tail_load;

  // Handshake flags depend only on the registered state.
  assign rq_ready = (state != FULL);
  assign rs_valid = (state != EMPTY);
  assign push     = rq_valid && rq_ready;
  assign pop      = rs_valid && rs_ready;
  assign rs_data  = head_data;

  // Head is loaded from the request when it is (or is about to become) the
  // only entry; the tail only ever holds the second-oldest response.
  assign head_load      = push && ((state == EMPTY) || (state == ONE && pop));
  assign tail_load      = push && (state == ONE) && !pop;
  assign head_from_tail = pop && (state == FULL);

`ifdef VXE_REG_RDPORT_RANGE_CHECK_EN
  logic rd_hit;
  logic head_err;
  logic tail_err;
`endif

  // NOTE: always_comb gives every output a default before the loop, so the
  // out-of-range case yields zero instead of inferring a latch.
  always_comb begin
    rd_data = '0;
`ifdef VXE_REG_RDPORT_RANGE_CHECK_EN
    rd_hit  = 1'b0;
`endif
    for (int i = 0; i < NREGS; i++) begin
      if (rq_addr == ADDR_WIDTH'(i)) begin
        rd_data = reg_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef VXE_REG_RDPORT_RANGE_CHECK_EN
        rd_hit  = 1'b1;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state <= ONE;
        ONE:     if (push && !pop) state <= FULL;
                 else if (pop && !push) state <= EMPTY;
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // NOTE: the buffer entries are reset even though they are data storage,
  // because rs_data must read zero while reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data <= '0;
      tail_data <= '0;
    end else begin
      if (head_load)           head_data <= rd_data;
      else if (head_from_tail) head_data <= tail_data;
      if (tail_load)           tail_data <= rd_data;
    end
  end

`ifdef VXE_REG_RDPORT_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_err <= 1'b0;
      tail_err <= 1'b0;
    end else begin
      if (head_load)           head_err <= !rd_hit;
      else if (head_from_tail) head_err <= tail_err;
      if (tail_load)           tail_err <= !rd_hit;
    end
  end

  assign rs_err = head_err;
`else
  assign rs_err = 1'b0;
`endif

endmodule
